mem_port_ctrl: RTL

Sequencer and arbiter for the single shared memory port. It sits between the MEM-stage outputs of the EX/MEM pipeline register (MemRead, MemWrite, ALU address, forwarded store data) and the instruction-fetch stage, and serializes their accesses onto one variable-latency memory handshake. It drives a global `stall_o` that freezes PC, IF/ID, ID/EX and EX/MEM while any access is outstanding. The data port has priority over fetch.

---
 rtl/mem_port_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// Shared memory-port sequencer: data access before fetch, one access at a time, global pipeline stall.
// Latency: mem_req_o one cycle after a request is seen, rdata valid the cycle after ack; stalls pipeline until served.
module mem_port_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        d_read_i,
   input  logic        d_write_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   input  logic        i_req_i,
   input  logic [31:0] i_addr_i,
   output logic [31:0] i_rdata_o,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        err_o
);

   typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        served_d_q, served_d_d;
   logic        served_i_q, served_i_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        err_q, err_d;

   logic        pend_d, pend_i, busy, timeout;
   logic [7:0]  cnt_inc;
   logic [31:0] fill;

   assign pend_d  = (d_read_i | d_write_i) & ~served_d_q;
   assign pend_i  = i_req_i & ~served_i_q;
   assign busy    = (state_q != IDLE);
   assign cnt_inc = cnt_q + 8'd1;
   assign timeout = busy & ~mem_ack_i & (cnt_inc == TO);
   // An aborted read returns zero rather than whatever is on the bus.
   assign fill    = mem_ack_i ? mem_rdata_i : 32'h0000_0000;

   always_comb begin
      state_d    = state_q;
      served_d_d = served_d_q;
      served_i_d = served_i_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      d_rdata_d  = d_rdata_q;
      i_rdata_d  = i_rdata_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (pend_d) begin
               state_d = DATA;
               addr_d  = d_addr_i;
               wdata_d = d_wdata_i;
               we_d    = d_write_i;
               cnt_d   = 8'd0;
            end else if (pend_i) begin
               state_d = INST;
               addr_d  = i_addr_i;
               we_d    = 1'b0;
               cnt_d   = 8'd0;
            end else begin
               // Advance cycle: the pipeline moves, so the next requests are new ones.
               served_d_d = 1'b0;
               served_i_d = 1'b0;
            end
         end
         DATA, INST: begin
            if (mem_ack_i || timeout) begin
               state_d = IDLE;
               if (state_q == DATA) begin
                  served_d_d = 1'b1;
                  if (!we_q) d_rdata_d = fill;
               end else begin
                  served_i_d = 1'b1;
                  i_rdata_d  = fill;
               end
               if (!mem_ack_i) err_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         served_d_q <= 1'b0;
         served_i_q <= 1'b0;
         cnt_q      <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         d_rdata_q  <= 32'h0;
         i_rdata_q  <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         served_d_q <= served_d_d;
         served_i_q <= served_i_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         d_rdata_q  <= d_rdata_d;
         i_rdata_q  <= i_rdata_d;
         err_q      <= err_d;
      end
   end

   assign stall_o     = busy | pend_d | pend_i;
   assign mem_req_o   = busy;
   assign mem_we_o    = busy & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign i_rdata_o   = i_rdata_q;
   assign err_o       = err_q;

endmodule
